// File: rtl/nn_pkg.sv
// Shared widths, operand/product/accumulator types and sequencer state encoding
// for the neuron MAC datapath.
package nn_pkg;
    localparam int DATA_W = 8;
    localparam int PROD_W = 16;
    localparam int ACC_W  = 32;

    typedef logic signed [DATA_W-1:0] data_t;
    typedef logic signed [PROD_W-1:0] prod_t;
    typedef logic signed [ACC_W-1:0]  acc_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_CAPTURE
    } seq_state_e;
endpackage

// File: rtl/mac_operand_mul.sv
// Registered signed 8x8->16 multiplier; output is forced to zero whenever the
// operands are not valid, so the accumulator can add it unconditionally.
module mac_operand_mul
    import nn_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     vld,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [PROD_W-1:0] p
);
    prod_t zin_d;
    prod_t zin_q;

    // Operands are sign-extended to the product width first; the full product fits.
    always_comb begin
        zin_d = '0;
        if (vld) begin
            zin_d = prod_t'(a) * prod_t'(b);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            zin_q <= '0;
        end else begin
            zin_q <= zin_d;
        end
    end

    assign p = zin_q;
endmodule

// File: rtl/neuron_mac_sequencer.sv
// Drives one neuron's dot product through the external accumulator: clears it,
// walks the x/w memories, drains the product pipe and captures the final sum.
module neuron_mac_sequencer
    import nn_pkg::*;
#(
    parameter int MAX_LEN = 256,
    parameter int ADDR_W  = $clog2(MAX_LEN),
    parameter int LEN_W   = ADDR_W + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [LEN_W-1:0]         len,
    output logic                     busy,
    output logic [ADDR_W-1:0]        x_addr,
    output logic [ADDR_W-1:0]        w_addr,
    input  logic signed [DATA_W-1:0] x_data,
    input  logic signed [DATA_W-1:0] w_data,
    output logic signed [PROD_W-1:0] zin,
    output logic                     acc_rst,
    input  logic signed [ACC_W-1:0]  accum,
    output logic signed [ACC_W-1:0]  result,
    output logic                     done
);
    // Worst-case |sum| is 16384*MAX_LEN, which must stay below 2^31.
    if (MAX_LEN > 65536) begin : g_max_len_check
        $error("MAX_LEN too large for accumulator headroom");
    end

    seq_state_e        state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [ADDR_W-1:0] index_q, index_d;
    logic              rd_valid_q, rd_valid_d;
    logic              drain_q, drain_d;
    acc_t              result_q, result_d;
    logic              done_q, done_d;

    logic [LEN_W-1:0]  len_clamp;
    logic [LEN_W-1:0]  last_idx;

    assign len_clamp = (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
    assign last_idx  = len_q - LEN_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            index_q    <= '0;
            rd_valid_q <= 1'b0;
            drain_q    <= 1'b0;
            result_q   <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            index_q    <= index_d;
            rd_valid_q <= rd_valid_d;
            drain_q    <= drain_d;
            result_q   <= result_d;
            done_q     <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && state_q == S_IDLE && start) begin
            assert (len <= LEN_W'(MAX_LEN));
        end
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        index_d    = index_q;
        drain_d    = 1'b0;
        result_d   = result_q;
        done_d     = 1'b0;
        rd_valid_d = (state_q == S_CLEAR) || (state_q == S_FEED);
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (len_clamp == '0) begin
                        result_d = '0;
                        done_d   = 1'b1;
                    end else begin
                        len_d   = len_clamp;
                        state_d = S_CLEAR;
                    end
                end
            end
            S_CLEAR: begin
                index_d = ADDR_W'(1);
                state_d = (len_q > LEN_W'(1)) ? S_FEED : S_DRAIN;
            end
            S_FEED: begin
                index_d = index_q + ADDR_W'(1);
                if ({1'b0, index_q} == last_idx) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Two cycles: one for the zin register, one for the accumulator add.
                drain_d = ~drain_q;
                if (drain_q) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                result_d = accum;
                done_d   = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy    = (state_q != S_IDLE);
        acc_rst = (state_q == S_CLEAR);
        x_addr  = (state_q == S_FEED) ? index_q : '0;
        w_addr  = x_addr;
        result  = result_q;
        done    = done_q;
    end

    mac_operand_mul u_mul (
        .clk (clk),
        .rst (rst),
        .vld (rd_valid_q),
        .a   (x_data),
        .b   (w_data),
        .p   (zin)
    );
endmodule

// File: tb/tb_neuron_mac_sequencer.sv
// Randomised and directed bench for neuron_mac_sequencer, with behavioural
// memories, accumulator and a dot-product reference model.
module tb_neuron_mac_sequencer;
    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [8:0]         len;
    logic               busy;
    logic [7:0]         x_addr;
    logic [7:0]         w_addr;
    logic signed [7:0]  x_data;
    logic signed [7:0]  w_data;
    logic signed [15:0] zin;
    logic               acc_rst;
    logic signed [31:0] accum;
    logic signed [31:0] result;
    logic               done;

    logic signed [7:0]  xmem [256];
    logic signed [7:0]  wmem [256];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    neuron_mac_sequencer dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .len     (len),
        .busy    (busy),
        .x_addr  (x_addr),
        .w_addr  (w_addr),
        .x_data  (x_data),
        .w_data  (w_data),
        .zin     (zin),
        .acc_rst (acc_rst),
        .accum   (accum),
        .result  (result),
        .done    (done)
    );

    // Synchronous-read memories and the 32-bit accumulator.
    always @(posedge clk) begin
        x_data <= xmem[x_addr];
        w_data <= wmem[w_addr];
        if (acc_rst) accum <= 32'sd0;
        else         accum <= accum + 32'(zin);
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Called at the mid-cycle point of T0; returns at the mid-cycle point of
    // the done cycle (or after an abort), leaving start low.
    task automatic run_neuron(input int n, input bit retrig, input int abort_at);
        int prods[$];
        int exp_sum  = 0;
        int done_cyc = (n == 0) ? 1 : n + 4;
        for (int k = 0; k < n; k++) begin
            int p = int'(xmem[k]) * int'(wmem[k]);
            prods.push_back(p);
            exp_sum += p;
        end
        start = 1'b1;
        len   = 9'(n);
        for (int c = 1; c <= done_cyc; c++) begin
            @(negedge clk);
            chk("acc_rst", int'(acc_rst), int'(n > 0 && c == 1));
            chk("busy", int'(busy), int'(n > 0 && c <= n + 3));
            chk("done", int'(done), int'(c == done_cyc));
            chk("zin", int'(zin), (c >= 3 && c <= n + 2) ? prods[c-3] : 0);
            if (c <= n) begin
                chk("x_addr", int'(x_addr), c - 1);
                chk("w_addr", int'(w_addr), c - 1);
            end
            if (c == done_cyc) chk("result", int'(result), exp_sum);
            if (c == abort_at) begin
                rst   = 1'b1;
                start = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                chk("abort_busy", int'(busy), 0);
                chk("abort_zin", int'(zin), 0);
                chk("abort_done", int'(done), 0);
                repeat (n + 4) begin
                    @(negedge clk);
                    chk("abort_no_done", int'(done), 0);
                    chk("abort_idle", int'(busy), 0);
                end
                return;
            end
            start = (retrig && c >= 2 && c <= 6) ? 1'b1 : 1'b0;
        end
    endtask

    initial begin
        int n;
        rst   = 1'b1;
        start = 1'b0;
        len   = '0;
        for (int k = 0; k < 256; k++) begin
            xmem[k] = '0;
            wmem[k] = '0;
        end
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_zin", int'(zin), 0);
        chk("rst_acc_rst", int'(acc_rst), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_x_addr", int'(x_addr), 0);
        rst = 1'b0;
        @(negedge clk);

        xmem[0] = 8'sd2;   xmem[1] = -8'sd3;  xmem[2] = 8'sd4;
        wmem[0] = 8'sd5;   wmem[1] = 8'sd6;   wmem[2] = -8'sd7;
        run_neuron(3, 1'b0, 0);
        chk("t1_result_val", int'(result), -36);
        @(negedge clk);

        xmem[0] = -8'sd128; xmem[1] = -8'sd128;
        wmem[0] = -8'sd128; wmem[1] = -8'sd128;
        run_neuron(2, 1'b0, 0);
        chk("t2_result_val", int'(result), 32768);
        repeat (2) @(negedge clk);

        run_neuron(0, 1'b0, 0);
        repeat (2) @(negedge clk);

        for (int k = 0; k < 4; k++) begin
            xmem[k] = 8'($urandom);
            wmem[k] = 8'($urandom);
        end
        run_neuron(4, 1'b1, 0);
        xmem[0] = 8'sd7;
        wmem[0] = -8'sd1;
        run_neuron(1, 1'b0, 0);
        chk("t4_b2b_result", int'(result), -7);
        @(negedge clk);

        for (int k = 0; k < 5; k++) begin
            xmem[k] = 8'($urandom);
            wmem[k] = 8'($urandom);
        end
        run_neuron(5, 1'b0, 3);
        xmem[0] = 8'sd3;
        wmem[0] = 8'sd3;
        run_neuron(1, 1'b0, 0);
        chk("t5_restart_result", int'(result), 9);
        @(negedge clk);

        for (int k = 0; k < 256; k++) begin
            xmem[k] = 8'sd1;
            wmem[k] = 8'sd1;
        end
        run_neuron(256, 1'b0, 0);
        chk("t6_full_result", int'(result), 256);
        @(negedge clk);

        for (int it = 0; it < 25; it++) begin
            n = $urandom_range(0, 40);
            for (int k = 0; k < n; k++) begin
                xmem[k] = 8'($urandom);
                wmem[k] = 8'($urandom);
            end
            run_neuron(n, (n >= 3) && ($urandom_range(0, 1) == 1), 0);
            if ($urandom_range(0, 2) != 0) begin
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
